// File: rtl/ex_pkg.sv
// Shared encodings for the pipelined execute stage: ALU opcodes, forwarding
// selects and the iterative-unit state type.
package ex_pkg;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SLL = 4'd3;
   localparam logic [3:0] ALU_SRL = 4'd4;
   localparam logic [3:0] ALU_SRA = 4'd5;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_MUL = 4'd8;
   localparam logic [3:0] ALU_DIV = 4'd9;
   localparam logic [3:0] ALU_NOR = 4'd12;

   localparam logic [1:0] FWD_REGFILE     = 2'd0;
   localparam logic [1:0] FWD_EXMEM       = 2'd1;
   localparam logic [1:0] FWD_MEMWB       = 2'd2;
   localparam logic [1:0] FWD_REGFILE_ALT = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } exState_e;

endpackage

// File: rtl/ex_iter_muldiv.sv
// Iterative shift-add multiplier (and restoring divider when EX_DIV_EN is
// defined); one bit per cycle for XLEN cycles, then holds DONE until acked.
module ex_iter_muldiv
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
`ifdef EX_DIV_EN
   input  logic            div_i,
`endif
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            ack_i,
   output logic            idle_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CNT_W = $clog2(XLEN);

   exState_e          state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   acc_q;
   logic [XLEN-1:0]   opA_q;
   logic [XLEN-1:0]   opB_q;

`ifdef EX_DIV_EN
   // Divide: acc_q is the partial remainder, opA_q shifts the dividend out
   // and the quotient in.
   logic            div_q;
   logic [XLEN:0]   remShift;
   logic            divGeq;

   always_comb begin
      remShift = {acc_q, opA_q[XLEN-1]};
      divGeq   = (remShift >= {1'b0, opB_q});
   end

   assign result_o = div_q ? opA_q : acc_q;
`else
   assign result_o = acc_q;
`endif

   assign idle_o = (state_q == ST_IDLE);
   assign done_o = (state_q == ST_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opA_q   <= '0;
         opB_q   <= '0;
`ifdef EX_DIV_EN
         div_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  acc_q   <= '0;
                  opA_q   <= a_i;
                  opB_q   <= b_i;
                  cnt_q   <= '0;
`ifdef EX_DIV_EN
                  div_q   <= div_i;
`endif
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
`ifdef EX_DIV_EN
               if (div_q) begin
                  if (divGeq) begin
                     acc_q <= remShift[XLEN-1:0] - opB_q;
                     opA_q <= {opA_q[XLEN-2:0], 1'b1};
                  end else begin
                     acc_q <= remShift[XLEN-1:0];
                     opA_q <= {opA_q[XLEN-2:0], 1'b0};
                  end
               end else
`endif
               begin
                  if (opB_q[0]) begin
                     acc_q <= acc_q + opA_q;
                  end
                  opA_q <= opA_q << 1;
                  opB_q <= opB_q >> 1;
               end
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(XLEN - 1)) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (ack_i) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ex_stage_pipelined.sv
// Execute stage with forwarding, ALU, iterative MUL (DIV with EX_DIV_EN)
// and a valid/ready EX/MEM pipeline register.
module ex_stage_pipelined
   import ex_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int REG_AW  = 5,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_alu_ctrl,
   input  logic               in_ALUSrc,
   input  logic               in_RegDst,
   input  logic               in_RegWrite,
   input  logic               in_MemWrite,
   input  logic               in_MemRead,
   input  logic               in_MemToReg,
   input  logic               in_branch,
   input  logic [1:0]         in_load_mode,
   input  logic [XLEN-1:0]    in_rs_data,
   input  logic [XLEN-1:0]    in_rt_data,
   input  logic [XLEN-1:0]    in_imm,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [REG_AW-1:0]  in_rt_idx,
   input  logic [REG_AW-1:0]  in_rd,
   input  logic [XLEN-1:0]    in_pc,
   input  logic [1:0]         fwd_a_sel,
   input  logic [1:0]         fwd_b_sel,
   input  logic [XLEN-1:0]    exmem_fwd_data,
   input  logic [XLEN-1:0]    memwb_fwd_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_RegWrite,
   output logic               out_MemWrite,
   output logic               out_MemRead,
   output logic               out_MemToReg,
   output logic               out_branch,
   output logic [1:0]         out_load_mode,
   output logic [REG_AW-1:0]  out_wb_dst,
   output logic [XLEN-1:0]    out_alu_result,
   output logic               out_zero,
   output logic [XLEN-1:0]    out_rt_data,
   output logic [XLEN-1:0]    out_branch_target
);

   typedef struct packed {
      logic              regWrite;
      logic              memWrite;
      logic              memRead;
      logic              memToReg;
      logic              branch;
      logic [1:0]        loadMode;
      logic [REG_AW-1:0] wbDst;
      logic [XLEN-1:0]   rtData;
      logic [XLEN-1:0]   branchTarget;
   } ctl_t;

   ctl_t            ctl_d, ctl_q, lat_q;
   logic [XLEN-1:0] result_q;
   logic            zero_q;
   logic            outValid_q;

   logic [XLEN-1:0] opA, opB, aluB, aluRes, mdResult;
   logic            isMulDiv, accept, mdStart, mdLoad, unitIdle, unitDone;

`ifdef EX_DIV_EN
   logic isDiv;
   assign isDiv    = (in_alu_ctrl == ALU_DIV);
   assign isMulDiv = (in_alu_ctrl == ALU_MUL) || isDiv;
`else
   assign isMulDiv = (in_alu_ctrl == ALU_MUL);
`endif

   assign in_ready = unitIdle && (!outValid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign mdStart  = accept && isMulDiv;
   assign mdLoad   = unitDone && (!outValid_q || out_ready);

   // Store data is the forwarded B operand, taken before the immediate mux.
   always_comb begin
      opA = in_rs_data;
      case (fwd_a_sel)
         FWD_EXMEM:       opA = exmem_fwd_data;
         FWD_MEMWB:       opA = memwb_fwd_data;
         FWD_REGFILE,
         FWD_REGFILE_ALT: opA = in_rs_data;
      endcase
      opB = in_rt_data;
      case (fwd_b_sel)
         FWD_EXMEM:       opB = exmem_fwd_data;
         FWD_MEMWB:       opB = memwb_fwd_data;
         FWD_REGFILE,
         FWD_REGFILE_ALT: opB = in_rt_data;
      endcase
      aluB = in_ALUSrc ? in_imm : opB;

      aluRes = '0;
      case (in_alu_ctrl)
         ALU_AND: aluRes = opA & aluB;
         ALU_OR:  aluRes = opA | aluB;
         ALU_ADD: aluRes = opA + aluB;
         ALU_SLL: aluRes = aluB << in_shamt;
         ALU_SRL: aluRes = aluB >> in_shamt;
         ALU_SRA: aluRes = $signed(aluB) >>> in_shamt;
         ALU_SUB: aluRes = opA - aluB;
         ALU_SLT: aluRes = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(aluB))};
         ALU_NOR: aluRes = ~(opA | aluB);
         ALU_MUL,
         ALU_DIV: aluRes = '0;
         default: aluRes = '0;
      endcase

      ctl_d.regWrite     = in_RegWrite;
      ctl_d.memWrite     = in_MemWrite;
      ctl_d.memRead      = in_MemRead;
      ctl_d.memToReg     = in_MemToReg;
      ctl_d.branch       = in_branch;
      ctl_d.loadMode     = in_load_mode;
      ctl_d.wbDst        = in_RegDst ? in_rd : in_rt_idx;
      ctl_d.rtData       = opB;
      ctl_d.branchTarget = in_pc + (in_imm << 2);
   end

   ex_iter_muldiv #(
      .XLEN(XLEN)
   ) u_muldiv (
      .clk      (clk),
      .reset    (reset),
      .start_i  (mdStart),
`ifdef EX_DIV_EN
      .div_i    (isDiv),
`endif
      .a_i      (opA),
      .b_i      (aluB),
      .ack_i    (mdLoad),
      .idle_o   (unitIdle),
      .done_o   (unitDone),
      .result_o (mdResult)
   );

   // Multi-cycle ops park their pass-through fields in lat_q until the unit is done.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctl_q      <= '0;
         lat_q      <= '0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         outValid_q <= 1'b0;
      end else begin
         if (mdStart) begin
            lat_q <= ctl_d;
         end
         if (accept && !isMulDiv) begin
            ctl_q      <= ctl_d;
            result_q   <= aluRes;
            zero_q     <= (aluRes == '0);
            outValid_q <= 1'b1;
         end else if (mdLoad) begin
            ctl_q      <= lat_q;
            result_q   <= mdResult;
            zero_q     <= (mdResult == '0);
            outValid_q <= 1'b1;
         end else if (out_ready) begin
            outValid_q <= 1'b0;
         end
      end
   end

   assign out_valid         = outValid_q;
   assign out_RegWrite      = ctl_q.regWrite;
   assign out_MemWrite      = ctl_q.memWrite;
   assign out_MemRead       = ctl_q.memRead;
   assign out_MemToReg      = ctl_q.memToReg;
   assign out_branch        = ctl_q.branch;
   assign out_load_mode     = ctl_q.loadMode;
   assign out_wb_dst        = ctl_q.wbDst;
   assign out_alu_result    = result_q;
   assign out_zero          = zero_q;
   assign out_rt_data       = ctl_q.rtData;
   assign out_branch_target = ctl_q.branchTarget;

endmodule

// File: tb/tb_ex_stage_pipelined.sv
// Scoreboard bench for ex_stage_pipelined: directed cases then randomized
// traffic with random MEM back-pressure. Build with EX_DIV_EN to cover divide.
module tb_ex_stage_pipelined;

   localparam int XLEN    = 32;
   localparam int REG_AW  = 5;
   localparam int SHAMT_W = 5;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [3:0]         in_alu_ctrl;
   logic               in_ALUSrc, in_RegDst;
   logic               in_RegWrite, in_MemWrite, in_MemRead, in_MemToReg, in_branch;
   logic [1:0]         in_load_mode;
   logic [XLEN-1:0]    in_rs_data, in_rt_data, in_imm, in_pc;
   logic [SHAMT_W-1:0] in_shamt;
   logic [REG_AW-1:0]  in_rt_idx, in_rd;
   logic [1:0]         fwd_a_sel, fwd_b_sel;
   logic [XLEN-1:0]    exmem_fwd_data, memwb_fwd_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_RegWrite, out_MemWrite, out_MemRead, out_MemToReg, out_branch;
   logic [1:0]         out_load_mode;
   logic [REG_AW-1:0]  out_wb_dst;
   logic [XLEN-1:0]    out_alu_result;
   logic               out_zero;
   logic [XLEN-1:0]    out_rt_data, out_branch_target;

   typedef struct packed {
      logic [3:0]         op;
      logic               aluSrc, regDst;
      logic               rw, mw, mr, m2r, br;
      logic [1:0]         lm;
      logic [XLEN-1:0]    rs, rt, imm;
      logic [SHAMT_W-1:0] shamt;
      logic [REG_AW-1:0]  rtIdx, rd;
      logic [XLEN-1:0]    pc;
      logic [1:0]         fwdA, fwdB;
      logic [XLEN-1:0]    exmem, memwb;
   } instr_t;

   typedef struct packed {
      logic              rw, mw, mr, m2r, br;
      logic [1:0]        lm;
      logic [REG_AW-1:0] dst;
      logic [XLEN-1:0]   res;
      logic              zero;
      logic [XLEN-1:0]   rtd, bt;
   } exp_t;

   exp_t expQ[$];
   int   testsRun    = 0;
   int   testsFailed = 0;
   bit   randReady   = 1'b0;

   ex_stage_pipelined #(
      .XLEN(XLEN), .REG_AW(REG_AW), .SHAMT_W(SHAMT_W)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_ctrl(in_alu_ctrl), .in_ALUSrc(in_ALUSrc), .in_RegDst(in_RegDst),
      .in_RegWrite(in_RegWrite), .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead),
      .in_MemToReg(in_MemToReg), .in_branch(in_branch), .in_load_mode(in_load_mode),
      .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
      .in_shamt(in_shamt), .in_rt_idx(in_rt_idx), .in_rd(in_rd), .in_pc(in_pc),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .exmem_fwd_data(exmem_fwd_data), .memwb_fwd_data(memwb_fwd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_RegWrite(out_RegWrite), .out_MemWrite(out_MemWrite), .out_MemRead(out_MemRead),
      .out_MemToReg(out_MemToReg), .out_branch(out_branch), .out_load_mode(out_load_mode),
      .out_wb_dst(out_wb_dst), .out_alu_result(out_alu_result), .out_zero(out_zero),
      .out_rt_data(out_rt_data), .out_branch_target(out_branch_target)
   );

   always #5 clk = ~clk;

   // Reference model: what MEM should see for one instruction, from the ISA rules.
   function automatic exp_t model(instr_t t);
      exp_t              e;
      logic [XLEN-1:0]   a, b, bs, r;
      logic [2*XLEN-1:0] prod;
      a  = (t.fwdA == 2'd1) ? t.exmem : (t.fwdA == 2'd2) ? t.memwb : t.rs;
      b  = (t.fwdB == 2'd1) ? t.exmem : (t.fwdB == 2'd2) ? t.memwb : t.rt;
      bs = t.aluSrc ? t.imm : b;
      prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, bs};
      case (t.op)
         4'd0:  r = a & bs;
         4'd1:  r = a | bs;
         4'd2:  r = a + bs;
         4'd3:  r = bs << t.shamt;
         4'd4:  r = bs >> t.shamt;
         4'd5:  r = $signed(bs) >>> t.shamt;
         4'd6:  r = a - bs;
         4'd7:  r = ($signed(a) < $signed(bs)) ? 32'd1 : 32'd0;
         4'd8:  r = prod[XLEN-1:0];
`ifdef EX_DIV_EN
         4'd9:  r = (bs == 0) ? {XLEN{1'b1}} : a / bs;
`endif
         4'd12: r = ~(a | bs);
         default: r = '0;
      endcase
      e.rw   = t.rw;  e.mw = t.mw; e.mr = t.mr; e.m2r = t.m2r; e.br = t.br;
      e.lm   = t.lm;
      e.dst  = t.regDst ? t.rd : t.rtIdx;
      e.res  = r;
      e.zero = (r == 0);
      e.rtd  = b;
      e.bt   = t.pc + t.imm * 4;
      return e;
   endfunction

   function automatic instr_t baseInstr();
      instr_t t;
      t = '0;
      t.rw = 1'($urandom); t.mw = 1'($urandom); t.mr = 1'($urandom);
      t.m2r = 1'($urandom); t.br = 1'($urandom); t.lm = 2'($urandom);
      t.regDst = 1'($urandom);
      t.rtIdx = REG_AW'($urandom); t.rd = REG_AW'($urandom);
      t.pc = $urandom & 32'hFFFF_FFFC;
      t.exmem = $urandom; t.memwb = $urandom;
      return t;
   endfunction

   function automatic logic [XLEN-1:0] randData();
      return ($urandom_range(0, 1) == 0) ? XLEN'($urandom_range(0, 15)) : XLEN'($urandom);
   endfunction

   function automatic instr_t randInstr();
      instr_t t;
      t = baseInstr();
      t.op = 4'($urandom_range(0, 15));
      t.aluSrc = 1'($urandom);
      t.rs = randData(); t.rt = randData(); t.imm = randData();
      t.exmem = randData(); t.memwb = randData();
      t.shamt = SHAMT_W'($urandom);
      t.fwdA = 2'($urandom); t.fwdB = 2'($urandom);
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [XLEN-1:0] got,
                              input logic [XLEN-1:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic present(input instr_t t);
      in_valid = 1'b1;
      in_alu_ctrl = t.op; in_ALUSrc = t.aluSrc; in_RegDst = t.regDst;
      in_RegWrite = t.rw; in_MemWrite = t.mw; in_MemRead = t.mr;
      in_MemToReg = t.m2r; in_branch = t.br; in_load_mode = t.lm;
      in_rs_data = t.rs; in_rt_data = t.rt; in_imm = t.imm; in_shamt = t.shamt;
      in_rt_idx = t.rtIdx; in_rd = t.rd; in_pc = t.pc;
      fwd_a_sel = t.fwdA; fwd_b_sel = t.fwdB;
      exmem_fwd_data = t.exmem; memwb_fwd_data = t.memwb;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic waitAccept(input instr_t t, output int waited);
      waited = 0;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            expQ.push_back(model(t));
            @(posedge clk); #1;
            in_valid = 1'b0;
            break;
         end
         if (waited >= 300) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            break;
         end
         waited++;
         @(posedge clk); #1;
      end
   endtask

   task automatic applyStimulus(input instr_t t);
      int w;
      present(t);
      waitAccept(t, w);
   endtask

   // Waits for out_valid; reports cycles without valid and cycles with in_ready low.
   task automatic expectResult(input string name, input logic [XLEN-1:0] exp,
                               input int maxWait, output int waited, output int readyLow);
      waited = 0;
      readyLow = 0;
      forever begin
         @(negedge clk);
         if (!in_ready) readyLow++;
         if (out_valid) begin
            checkOutput(name, out_alu_result, exp);
            break;
         end
         if (waited >= maxWait) begin
            checkOutput({name, "_timeout"}, 32'd0, 32'd1);
            break;
         end
         waited++;
      end
      @(posedge clk); #1;
   endtask

   // Monitor: every cycle MEM sees a valid entry it must match the queue head;
   // the head retires only on the handshake, so held outputs are checked too.
   always @(negedge clk) begin
      exp_t got;
      if (!reset && out_valid) begin
         got = {out_RegWrite, out_MemWrite, out_MemRead, out_MemToReg, out_branch,
                out_load_mode, out_wb_dst, out_alu_result, out_zero, out_rt_data,
                out_branch_target};
         testsRun++;
         if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL unexpected_output got=%h exp=none", got);
         end else begin
            if (got !== expQ[0]) begin
               testsFailed++;
               $display("[TB] FAIL exmem_fields got=%h exp=%h", got, expQ[0]);
            end
            if (out_ready) void'(expQ.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog got=running exp=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      instr_t t, t2;
      int     w, rl;
      exp_t   got;

      reset = 1'b1; out_ready = 1'b1;
      present('0);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      got = {out_RegWrite, out_MemWrite, out_MemRead, out_MemToReg, out_branch,
             out_load_mode, out_wb_dst, out_alu_result, out_zero, out_rt_data,
             out_branch_target};
      checkOutput("reset_valid", XLEN'(out_valid), 32'd0);
      testsRun++;
      if (got !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset_fields got=%h exp=0", got);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_in_ready", XLEN'(in_ready), 32'd1);
      @(posedge clk); #1;

      t = baseInstr(); t.op = 4'd2; t.rs = 5; t.imm = 7; t.aluSrc = 1'b1;
      applyStimulus(t);
      expectResult("add", 32'd12, 0, w, rl);
      checkOutput("add_zero", XLEN'(out_zero), 32'd0);

      t = baseInstr(); t.op = 4'd6; t.rs = 32'd123; t.rt = 9; t.fwdA = 2'd1; t.exmem = 9;
      applyStimulus(t);
      expectResult("sub_fwd", 32'd0, 0, w, rl);
      checkOutput("sub_zero", XLEN'(out_zero), 32'd1);

      t = baseInstr(); t.op = 4'd7; t.rs = 32'hFFFF_FFFF; t.rt = 1;
      applyStimulus(t);
      expectResult("slt_signed", 32'd1, 0, w, rl);

      t = baseInstr(); t.op = 4'd5; t.rt = 32'h8000_0000; t.shamt = 4;
      applyStimulus(t);
      expectResult("sra", 32'hF800_0000, 0, w, rl);

      t = baseInstr(); t.op = 4'd0; t.pc = 32'h100; t.imm = 32'hFFFF_FFFF;
      applyStimulus(t);
      expectResult("branch_op", 32'd0, 0, w, rl);
      checkOutput("branch_target", out_branch_target, 32'h0000_00FC);

      t = baseInstr(); t.op = 4'd8; t.rs = 7; t.rt = 6;
      applyStimulus(t);
      expectResult("mul", 32'd42, 60, w, rl);
      checkOutput("mul_latency", w, XLEN + 1);
      checkOutput("mul_ready_low", rl, XLEN + 1);

      // Reset mid-multiply: the pending product must never reach MEM.
      t = baseInstr(); t.op = 4'd8; t.rs = 3; t.rt = 5;
      applyStimulus(t);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      expQ.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_mul_valid", XLEN'(out_valid), 32'd0);
      checkOutput("rst_mul_in_ready", XLEN'(in_ready), 32'd1);
      repeat (XLEN + 8) @(posedge clk);
      #1;

      // Back-pressure: held result, stalled upstream, same-cycle accept on release.
      out_ready = 1'b0;
      t = baseInstr(); t.op = 4'd2; t.rs = 100; t.rt = 23;
      applyStimulus(t);
      t2 = baseInstr(); t2.op = 4'd1; t2.rs = 32'hF0; t2.rt = 32'h0F;
      present(t2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_in_ready_low", XLEN'(in_ready), 32'd0);
         checkOutput("bp_hold_result", out_alu_result, 32'd123);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      waitAccept(t2, w);
      checkOutput("bp_release_accept", w, 32'd0);
      expectResult("bp_second", 32'hFF, 0, w, rl);

`ifdef EX_DIV_EN
      t = baseInstr(); t.op = 4'd9; t.rs = 100; t.rt = 7;
      applyStimulus(t);
      expectResult("div", 32'd14, 60, w, rl);
      checkOutput("div_latency", w, XLEN + 1);
      t = baseInstr(); t.op = 4'd9; t.rs = 5; t.rt = 0;
      applyStimulus(t);
      expectResult("div_by_zero", 32'hFFFF_FFFF, 60, w, rl);
`else
      t = baseInstr(); t.op = 4'd9; t.rs = 100; t.rt = 7;
      applyStimulus(t);
      expectResult("op9_no_div", 32'd0, 0, w, rl);
`endif

      randReady = 1'b1;
      for (int n = 0; n < 80; n++) begin
         applyStimulus(randInstr());
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      randReady = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 200 && expQ.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      checkOutput("drain_queue_empty", expQ.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
